// File: rtl/spi_xfer_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : spi_xfer_ctrl
// Description : SPI master transfer sequencer (IDLE/LOAD/TRANSFER/DONE).
//               Programmable SCLK divider, CPOL/CPHA modes, one word per
//               start handshake. Optional macro SPI_LSB_FIRST_EN adds
//               i_lsb_first for LSB-first shifting.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_xfer_ctrl #(
  parameter int DATA_W = 8,
  parameter int DIV_W  = 8
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic [DATA_W-1:0] i_tx_data,
  input  logic [1:0]        i_ss,
  input  logic [DIV_W-1:0]  i_div,
  input  logic              i_cpol,
  input  logic              i_cpha,
  input  logic              i_abort,
`ifdef SPI_LSB_FIRST_EN
  input  logic              i_lsb_first,
`endif
  input  logic              i_miso,
  output logic              o_ready,
  output logic              o_busy,
  output logic [1:0]        o_state,
  output logic [1:0]        o_ss,
  output logic              o_sclk,
  output logic              o_mosi,
  output logic [DATA_W-1:0] o_rx_data,
  output logic              o_done
);

  // State encoding is visible on o_state and consumed by the CS generator.
  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_LOAD = 2'b01;
  localparam logic [1:0] ST_XFER = 2'b10;
  localparam logic [1:0] ST_DONE = 2'b11;

  localparam int                 ECNT_W    = $clog2(2 * DATA_W + 1);
  localparam logic [ECNT_W-1:0]  LAST_EDGE = ECNT_W'(2 * DATA_W - 1);
  localparam logic [ECNT_W-1:0]  EDGE_ONE  = 1;
  localparam logic [DIV_W-1:0]   HALF_ONE  = 1;

  logic [1:0]        state_q, state_d;
  logic [DIV_W-1:0]  half_q, half_d;
  logic [ECNT_W-1:0] edge_q, edge_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic              cpol_q, cpol_d;
  logic              cpha_q, cpha_d;
  logic [1:0]        ss_q, ss_d;
  logic [DATA_W-1:0] tx_sh_q, tx_sh_d;
  logic [DATA_W-1:0] rx_sh_q, rx_sh_d;
  logic [DATA_W-1:0] rx_data_q, rx_data_d;
  logic              sclk_q, sclk_d;
  logic              mosi_q, mosi_d;

  // Bit order: fixed MSB-first unless the optional feature is built in.
  logic lsb_first;
  logic lsb_first_in;
`ifdef SPI_LSB_FIRST_EN
  logic lsb_first_q, lsb_first_d;
  assign lsb_first    = lsb_first_q;
  assign lsb_first_in = i_lsb_first;
`else
  assign lsb_first    = 1'b0;
  assign lsb_first_in = 1'b0;
`endif

  logic              w_accept;
  logic              w_half_wrap;
  logic              w_last_edge;
  logic              w_tx_bit;
  logic [DATA_W-1:0] w_tx_shift;
  logic [DATA_W-1:0] w_rx_shift;

  assign w_accept    = i_start && (state_q == ST_IDLE);
  assign w_half_wrap = (half_q == div_q);
  assign w_last_edge = w_half_wrap && (edge_q == LAST_EDGE);
  assign w_tx_bit    = lsb_first ? tx_sh_q[0] : tx_sh_q[DATA_W-1];
  assign w_tx_shift  = lsb_first ? (tx_sh_q >> 1) : (tx_sh_q << 1);
  assign w_rx_shift  = lsb_first ? {i_miso, rx_sh_q[DATA_W-1:1]}
                                 : {rx_sh_q[DATA_W-2:0], i_miso};

  // State and datapath registers; reset aborts any transfer immediately.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= ST_IDLE;
      half_q    <= '0;
      edge_q    <= '0;
      div_q     <= '0;
      cpol_q    <= 1'b0;
      cpha_q    <= 1'b0;
      ss_q      <= '0;
      tx_sh_q   <= '0;
      rx_sh_q   <= '0;
      rx_data_q <= '0;
      sclk_q    <= 1'b0;
      mosi_q    <= 1'b0;
`ifdef SPI_LSB_FIRST_EN
      lsb_first_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      half_q    <= half_d;
      edge_q    <= edge_d;
      div_q     <= div_d;
      cpol_q    <= cpol_d;
      cpha_q    <= cpha_d;
      ss_q      <= ss_d;
      tx_sh_q   <= tx_sh_d;
      rx_sh_q   <= rx_sh_d;
      rx_data_q <= rx_data_d;
      sclk_q    <= sclk_d;
      mosi_q    <= mosi_d;
`ifdef SPI_LSB_FIRST_EN
      lsb_first_q <= lsb_first_d;
`endif
    end
  end

  // Next-state logic: abort only acts in LOAD and TRANSFER.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (i_start)            state_d = ST_LOAD;
      ST_LOAD: if (i_abort)            state_d = ST_IDLE;
               else if (w_half_wrap)   state_d = ST_XFER;
      ST_XFER: if (i_abort)            state_d = ST_IDLE;
               else if (w_last_edge)   state_d = ST_DONE;
      ST_DONE:                         state_d = ST_IDLE;
      default:                         state_d = ST_IDLE;
    endcase
  end

  // Datapath: latch config on accept, count half-periods, shift on SCLK edges.
  always_comb begin
    half_d    = half_q;
    edge_d    = edge_q;
    div_d     = div_q;
    cpol_d    = cpol_q;
    cpha_d    = cpha_q;
    ss_d      = ss_q;
    tx_sh_d   = tx_sh_q;
    rx_sh_d   = rx_sh_q;
    rx_data_d = rx_data_q;
    sclk_d    = sclk_q;
    mosi_d    = mosi_q;
`ifdef SPI_LSB_FIRST_EN
    lsb_first_d = lsb_first_q;
`endif
    case (state_q)
      ST_IDLE: begin
        half_d = '0;
        edge_d = '0;
        mosi_d = 1'b0;
        sclk_d = cpol_q;
        if (w_accept) begin
          div_d   = i_div;
          cpol_d  = i_cpol;
          cpha_d  = i_cpha;
          ss_d    = i_ss;
          sclk_d  = i_cpol;
          rx_sh_d = '0;
`ifdef SPI_LSB_FIRST_EN
          lsb_first_d = i_lsb_first;
`endif
          // CPHA=0 presents the first bit during CS setup.
          if (!i_cpha) begin
            mosi_d  = lsb_first_in ? i_tx_data[0] : i_tx_data[DATA_W-1];
            tx_sh_d = lsb_first_in ? (i_tx_data >> 1) : (i_tx_data << 1);
          end else begin
            tx_sh_d = i_tx_data;
          end
        end
      end
      ST_LOAD: begin
        if (i_abort) begin
          half_d = '0;
          sclk_d = cpol_q;
          mosi_d = 1'b0;
        end else if (w_half_wrap) begin
          half_d = '0;
        end else begin
          half_d = half_q + HALF_ONE;
        end
      end
      ST_XFER: begin
        if (i_abort) begin
          half_d = '0;
          edge_d = '0;
          sclk_d = cpol_q;
          mosi_d = 1'b0;
        end else if (w_half_wrap) begin
          half_d = '0;
          edge_d = edge_q + EDGE_ONE;
          sclk_d = ~sclk_q;
          // edge_q even means this is an odd-numbered (leading) edge.
          if ((~edge_q[0]) ^ cpha_q) begin
            rx_sh_d = w_rx_shift;
          end else begin
            mosi_d  = w_tx_bit;
            tx_sh_d = w_tx_shift;
          end
          if (edge_q == LAST_EDGE) begin
            edge_d    = '0;
            mosi_d    = 1'b0;
            rx_data_d = rx_sh_d;
          end
        end else begin
          half_d = half_q + HALF_ONE;
        end
      end
      default: begin
        half_d = '0;
        edge_d = '0;
        mosi_d = 1'b0;
      end
    endcase
  end

  // Outputs decoded from state plus registered serial lines.
  always_comb begin
    o_ready   = (state_q == ST_IDLE);
    o_busy    = (state_q != ST_IDLE);
    o_done    = (state_q == ST_DONE);
    o_state   = state_q;
    o_ss      = ss_q;
    o_sclk    = sclk_q;
    o_mosi    = mosi_q;
    o_rx_data = rx_data_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_spi_xfer_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_spi_xfer_ctrl
// Description : Self-checking bench for spi_xfer_ctrl with a behavioural
//               SPI slave and a cycle-count reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_xfer_ctrl;
  localparam int DATA_W = 8;
  localparam int DIV_W  = 8;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic [DATA_W-1:0] tx = '0;
  logic [1:0]        ss = '0;
  logic [DIV_W-1:0]  div = '0;
  logic              cpol = 1'b0;
  logic              cpha = 1'b0;
  logic              abort = 1'b0;
  logic              lsb = 1'b0;
  logic              slv_en = 1'b0;
  logic              slv_bit = 1'b0;
  logic              miso;

  logic              o_ready, o_busy, o_sclk, o_mosi, o_done;
  logic [1:0]        o_state, o_ss;
  logic [DATA_W-1:0] o_rx_data;

  int checks = 0;
  int failures = 0;

  // Slave either loops MOSI back or drives its own word.
  assign miso = slv_en ? slv_bit : o_mosi;

  always #5 clk = ~clk;

  spi_xfer_ctrl #(.DATA_W(DATA_W), .DIV_W(DIV_W)) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_start    (start),
    .i_tx_data  (tx),
    .i_ss       (ss),
    .i_div      (div),
    .i_cpol     (cpol),
    .i_cpha     (cpha),
    .i_abort    (abort),
`ifdef SPI_LSB_FIRST_EN
    .i_lsb_first(lsb),
`endif
    .i_miso     (miso),
    .o_ready    (o_ready),
    .o_busy     (o_busy),
    .o_state    (o_state),
    .o_ss       (o_ss),
    .o_sclk     (o_sclk),
    .o_mosi     (o_mosi),
    .o_rx_data  (o_rx_data),
    .o_done     (o_done)
  );

  // k-th bit on the wire for a word, honouring bit order.
  function automatic logic wire_bit(input logic [DATA_W-1:0] w, input int k);
    return lsb ? w[k] : w[DATA_W-1-k];
  endfunction

  // One full transfer against the reference: timing, states, bits, result.
  task automatic do_xfer(input logic [7:0] t_tx, input logic [7:0] t_div,
                         input logic t_cpol, input logic t_cpha, input logic [1:0] t_ss,
                         input logic t_slv, input logic [7:0] t_sw, input string name);
    int hp, done_cyc, cyc, edges, rises, sidx, midx;
    int bad_state, bad_edge, bad_mosi;
    logic [1:0] bad_state_val;
    logic prev_sclk, prev_mosi, lead, got_done;
    logic [DATA_W-1:0] exp_rx;
    logic [1:0] exp_st;
    hp       = int'(t_div) + 1;
    done_cyc = 1 + hp + 2 * DATA_W * hp;
    exp_rx   = t_slv ? t_sw : t_tx;
    @(negedge clk);
    checks++;
    if (o_ready !== 1'b1) begin
      failures++;
      $display("FAIL %s_ready_before got=%b want=1", name, o_ready);
    end
    tx = t_tx; div = t_div; cpol = t_cpol; cpha = t_cpha; ss = t_ss;
    slv_en = t_slv; sidx = 0;
    if (t_slv && !t_cpha) begin
      slv_bit = wire_bit(t_sw, 0);
      sidx = 1;
    end
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    cyc = 0; edges = 0; rises = 0; midx = 0;
    bad_state = -1; bad_edge = -1; bad_mosi = -1; bad_state_val = 2'b00;
    prev_sclk = t_cpol; prev_mosi = 1'b0; got_done = 1'b0;
    while (!got_done && cyc < done_cyc + 4) begin
      @(negedge clk);
      cyc++;
      exp_st = (cyc <= hp) ? 2'b01 : (cyc < done_cyc) ? 2'b10 :
               (cyc == done_cyc) ? 2'b11 : 2'b00;
      if (o_state !== exp_st && bad_state < 0) begin
        bad_state = cyc; bad_state_val = o_state;
      end
      if (cyc == 1) begin
        checks++;
        if (o_mosi !== (t_cpha ? 1'b0 : wire_bit(t_tx, 0)) || o_sclk !== t_cpol) begin
          failures++;
          $display("FAIL %s_load_lines mosi=%b sclk=%b want mosi=%b sclk=%b", name,
                   o_mosi, o_sclk, t_cpha ? 1'b0 : wire_bit(t_tx, 0), t_cpol);
        end
      end
      if (o_sclk !== prev_sclk) begin
        edges++;
        if (cyc != (edges + 1) * hp + 1 && bad_edge < 0) bad_edge = cyc;
        if (o_sclk === 1'b1) rises++;
        lead = (edges % 2) == 1;
        if (lead != t_cpha) begin
          // Slave samples the MOSI level present at the edge.
          if (midx < DATA_W && prev_mosi !== wire_bit(t_tx, midx) && bad_mosi < 0) bad_mosi = midx;
          midx++;
        end else if (t_slv && sidx < DATA_W) begin
          slv_bit = wire_bit(t_sw, sidx);
          sidx++;
        end
        prev_sclk = o_sclk;
      end
      prev_mosi = o_mosi;
      if (o_done === 1'b1) got_done = 1'b1;
    end
    checks++;
    if (!got_done || cyc != done_cyc) begin
      failures++;
      $display("FAIL %s_latency got_done=%b cycle=%0d want=%0d", name, got_done, cyc, done_cyc);
    end
    checks++;
    if (bad_state >= 0) begin
      failures++;
      $display("FAIL %s_state_seq cycle=%0d got=%b", name, bad_state, bad_state_val);
    end
    checks++;
    if (edges != 2 * DATA_W || rises != DATA_W || bad_edge >= 0) begin
      failures++;
      $display("FAIL %s_sclk edges=%0d rises=%0d bad_edge_cycle=%0d want edges=%0d rises=%0d",
               name, edges, rises, bad_edge, 2 * DATA_W, DATA_W);
    end
    checks++;
    if (bad_mosi >= 0) begin
      failures++;
      $display("FAIL %s_mosi_bits first bad bit index=%0d tx=%h", name, bad_mosi, t_tx);
    end
    checks++;
    if (o_rx_data !== exp_rx || o_sclk !== t_cpol || o_mosi !== 1'b0 || o_ss !== t_ss) begin
      failures++;
      $display("FAIL %s_done_outputs rx=%h sclk=%b mosi=%b ss=%0d want rx=%h sclk=%b mosi=0 ss=%0d",
               name, o_rx_data, o_sclk, o_mosi, o_ss, exp_rx, t_cpol, t_ss);
    end
    @(negedge clk);
    checks++;
    if (o_done !== 1'b0 || o_state !== 2'b00 || o_sclk !== t_cpol || o_rx_data !== exp_rx) begin
      failures++;
      $display("FAIL %s_after_done done=%b state=%b sclk=%b rx=%h want 0/00/%b/%h",
               name, o_done, o_state, o_sclk, o_rx_data, t_cpol, exp_rx);
    end
    slv_en = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({o_state, o_ready, o_busy, o_ss, o_sclk, o_mosi, o_done} !== 9'b00_1_0_00_0_0_0 ||
        o_rx_data !== '0) begin
      failures++;
      $display("FAIL reset_values state=%b rdy=%b busy=%b ss=%b sclk=%b mosi=%b done=%b rx=%h",
               o_state, o_ready, o_busy, o_ss, o_sclk, o_mosi, o_done, o_rx_data);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_mode0();
    do_xfer(8'hA5, 8'd0, 1'b0, 1'b0, 2'd1, 1'b0, 8'h00, "mode0");
  endtask

  task automatic test_mode3();
    do_xfer(8'h3C, 8'd3, 1'b1, 1'b1, 2'd0, 1'b1, 8'hC3, "mode3");
  endtask

  task automatic test_abort();
    logic [DATA_W-1:0] rx_before;
    int edges, cyc, ndone;
    logic prev;
    rx_before = o_rx_data;
    @(negedge clk);
    tx = 8'hFF; div = 8'd1; cpol = 1'b0; cpha = 1'b1; ss = 2'd0; slv_en = 1'b0;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    edges = 0; cyc = 0; prev = 1'b0;
    while (edges < 5 && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (o_sclk !== prev) begin edges++; prev = o_sclk; end
    end
    checks++;
    if (edges != 5) begin
      failures++;
      $display("FAIL abort_reach_edge5 edges=%0d want=5", edges);
    end
    abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    @(negedge clk);
    checks++;
    if (o_state !== 2'b00 || o_sclk !== 1'b0 || o_mosi !== 1'b0 || o_done !== 1'b0 ||
        o_rx_data !== rx_before) begin
      failures++;
      $display("FAIL abort_outputs state=%b sclk=%b mosi=%b done=%b rx=%h want 00/0/0/0/%h",
               o_state, o_sclk, o_mosi, o_done, o_rx_data, rx_before);
    end
    ndone = 0;
    repeat (40) begin
      @(negedge clk);
      if (o_done === 1'b1 || o_state !== 2'b00) ndone++;
    end
    checks++;
    if (ndone != 0) begin
      failures++;
      $display("FAIL abort_no_done activity_cycles=%0d want=0", ndone);
    end
  endtask

  task automatic test_hold_start();
    int cyc, first_done, bad_ss, reacc;
    logic seen_second;
    @(negedge clk);
    tx = 8'h5A; div = 8'd0; cpol = 1'b0; cpha = 1'b0; ss = 2'd2; slv_en = 1'b0;
    start = 1'b1;
    cyc = 0; first_done = -1; bad_ss = 0; reacc = 0; seen_second = 1'b0;
    while (!seen_second && cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) ss = 2'd1;
      if (first_done < 0) begin
        if (o_state !== 2'b00 && o_ss !== 2'd2) bad_ss++;
        if (cyc > 1 && o_state === 2'b01) reacc++;
        if (o_done === 1'b1) first_done = cyc;
      end else if (cyc == first_done + 1) begin
        checks++;
        if (o_state !== 2'b00) begin
          failures++;
          $display("FAIL hold_idle_gap state=%b want=00", o_state);
        end
      end else begin
        checks++;
        if (o_state !== 2'b01 || o_ss !== 2'd1) begin
          failures++;
          $display("FAIL hold_second_accept state=%b ss=%0d want 01/1", o_state, o_ss);
        end
        seen_second = 1'b1;
        start = 1'b0;
        abort = 1'b1;
      end
    end
    @(posedge clk);
    #1 abort = 1'b0;
    start = 1'b0;
    checks++;
    if (first_done != 18 || bad_ss != 0 || reacc != 0) begin
      failures++;
      $display("FAIL hold_first_xfer done_cycle=%0d bad_ss=%0d reaccepts=%0d want 18/0/0",
               first_done, bad_ss, reacc);
    end
    @(negedge clk);
    checks++;
    if (o_state !== 2'b00 || o_done !== 1'b0) begin
      failures++;
      $display("FAIL hold_abort_in_load state=%b done=%b want 00/0", o_state, o_done);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 8; i++) begin
      do_xfer(8'($urandom), 8'($urandom_range(0, 3)), 1'($urandom), 1'($urandom),
              2'($urandom), 1'($urandom), 8'($urandom), "random");
    end
  endtask

  task automatic test_div_max();
    do_xfer(8'h96, 8'hFF, 1'b1, 1'b0, 2'd3, 1'b1, 8'($urandom), "divmax");
  endtask

  task automatic test_lsb_first();
    lsb = 1'b1;
    do_xfer(8'h01, 8'd0, 1'b0, 1'b0, 2'd0, 1'b0, 8'h00, "lsb_loop");
    do_xfer(8'hB2, 8'd1, 1'b0, 1'b1, 2'd2, 1'b1, 8'h4D, "lsb_slave");
    lsb = 1'b0;
  endtask

  task automatic test_async_reset();
    int cyc;
    @(negedge clk);
    tx = 8'hA5; div = 8'd2; cpol = 1'b1; cpha = 1'b0; ss = 2'd3; slv_en = 1'b0;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    cyc = 0;
    while (o_state !== 2'b10 && cyc < 20) begin @(negedge clk); cyc++; end
    repeat (7) @(negedge clk);
    checks++;
    if (o_state !== 2'b10) begin
      failures++;
      $display("FAIL areset_in_transfer state=%b want=10", o_state);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({o_state, o_ready, o_busy, o_ss, o_sclk, o_mosi, o_done} !== 9'b00_1_0_00_0_0_0 ||
        o_rx_data !== '0) begin
      failures++;
      $display("FAIL areset_values state=%b rdy=%b busy=%b ss=%b sclk=%b mosi=%b done=%b rx=%h",
               o_state, o_ready, o_busy, o_ss, o_sclk, o_mosi, o_done, o_rx_data);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    checks++;
    if (o_state !== 2'b00 || o_done !== 1'b0 || o_sclk !== 1'b0) begin
      failures++;
      $display("FAIL areset_stays_idle state=%b done=%b sclk=%b want 00/0/0", o_state, o_done, o_sclk);
    end
  endtask

  initial begin
    test_reset();
    test_mode0();
    test_mode3();
    test_abort();
    test_hold_start();
    test_random();
    test_div_max();
`ifdef SPI_LSB_FIRST_EN
    test_lsb_first();
`endif
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
